// File: rtl/demux_prio_router_pkg.sv
// Shared definitions for the priority demux router and its match encoder.
//   state_e    : router FSM states (IDLE = nothing held, HOLD = word held)
//   DROP_CNT_W : width of the saturating dropped-word counter
package demux_prio_router_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam int DROP_CNT_W = 8;

   // Index width that stays legal when there is a single output.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/demux_prio_router_if.sv
// Handshake bundle between an upstream producer and the router outputs.
//   in_valid/in_ready/in_data : single input stream
//   sel                       : NUM_OUT select fields, field i at [i*SEL_W +: SEL_W]
//   out_valid/out_ready       : per-output handshake
//   out_data                  : word i at [i*DATA_W +: DATA_W]
// Modports: slave = router view, master = environment view.
interface demux_prio_router_if #(
   parameter int DATA_W  = 2,
   parameter int NUM_OUT = 2,
   parameter int SEL_W   = 2
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_W-1:0]         in_data;
   logic [NUM_OUT*SEL_W-1:0]  sel;
   logic [NUM_OUT-1:0]        out_valid;
   logic [NUM_OUT-1:0]        out_ready;
   logic [NUM_OUT*DATA_W-1:0] out_data;

   modport slave (
      input  in_valid, in_data, sel, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, sel, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/demux_prio_router_prio_match_enc.sv
// Combinational priority match encoder.
//   sel : NUM_OUT packed select fields
//   hit : some field equals MATCH
//   idx : lowest index whose field equals MATCH (0 when no hit)
module prio_match_enc
   import demux_prio_router_pkg::*;
#(
   parameter int                NUM_OUT = 2,
   parameter int                SEL_W   = 2,
   parameter logic [SEL_W-1:0]  MATCH   = '0,
   localparam int               IDX_W   = idx_w(NUM_OUT)
) (
   input  logic [NUM_OUT*SEL_W-1:0] sel,
   output logic                     hit,
   output logic [IDX_W-1:0]         idx
);

   // Scan high to low so the lowest matching index is the last write.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = NUM_OUT - 1; i >= 0; i--) begin
         if (sel[i*SEL_W +: SEL_W] == MATCH) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/demux_prio_router.sv
// Registered 1-to-N priority demultiplexer.
//   clk, rst_n  : clock, async active-low reset
//   bus         : handshake bundle (slave view)
//   drop_pulse  : one cycle after an accepted word matched no output
//   drop_count  : saturating count of dropped words
// An accepted word goes to the lowest output whose select field equals
// MATCH and is held there until that output takes it.
module demux_prio_router
   import demux_prio_router_pkg::*;
#(
   parameter int                DATA_W  = 2,
   parameter int                NUM_OUT = 2,
   parameter int                SEL_W   = 2,
   parameter logic [SEL_W-1:0]  MATCH   = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   demux_prio_router_if.slave     bus,
   output logic                   drop_pulse,
   output logic [DROP_CNT_W-1:0]  drop_count
);

   localparam int         IDX_W  = idx_w(NUM_OUT);
   localparam logic [0:0] S_IDLE = IDLE;
   localparam logic [0:0] S_HOLD = HOLD;

   logic [0:0]        state;
   logic [IDX_W-1:0]  dest;
   logic [DATA_W-1:0] data_q;

   logic              hit;
   logic [IDX_W-1:0]  idx;
   logic              dest_rdy;
   logic              rls;
   logic              acc;

   prio_match_enc #(
      .NUM_OUT (NUM_OUT),
      .SEL_W   (SEL_W),
      .MATCH   (MATCH)
   ) u_enc (
      .sel (bus.sel),
      .hit (hit),
      .idx (idx)
   );

   // Only the destination's ready matters; other outputs' readies are ignored.
   assign dest_rdy     = bus.out_ready[dest];
   assign rls          = (state == S_HOLD) && dest_rdy;
   assign bus.in_ready = (state == S_IDLE) || dest_rdy;
   assign acc          = bus.in_valid && bus.in_ready;

   // Outputs decode from state so an async reset clears them immediately,
   // and non-destination slots are structurally zero.
   for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
      logic sel_i;
      assign sel_i                            = (state == S_HOLD) && (dest == IDX_W'(i));
      assign bus.out_valid[i]                 = sel_i;
      assign bus.out_data[i*DATA_W +: DATA_W] = sel_i ? data_q : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         dest       <= '0;
         data_q     <= '0;
         drop_pulse <= 1'b0;
         drop_count <= '0;
      end else begin
         drop_pulse <= 1'b0;
         if (acc) begin
            // An accept while holding implies the held word is released now,
            // so the new word (or the drop) replaces it with no bubble.
            if (hit) begin
               state  <= S_HOLD;
               dest   <= idx;
               data_q <= bus.in_data;
            end else begin
               state      <= S_IDLE;
               data_q     <= '0;
               drop_pulse <= 1'b1;
               if (drop_count != '1)
                  drop_count <= drop_count + 1'b1;
            end
         end else if (rls) begin
            state  <= S_IDLE;
            data_q <= '0;
         end
      end
   end

endmodule
